// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter for the crossbar mux array. Each output runs an IDLE/BUSY FSM
// that grants one requester, drives the registered select/enable, and bounds contested hold time.
module xbar_rr_arbiter #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned N_OUT    = 4,
    parameter int unsigned SW       = $clog2(N_IN),
    parameter int unsigned DW       = $clog2(N_OUT),
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_IN-1:0]       REQ,
    input  logic [N_IN*DW-1:0]    DEST,
    output logic [N_IN-1:0]       GNT,
    output logic [N_OUT*SW-1:0]   SEL,
    output logic [N_OUT-1:0]      OEN
);

    localparam int unsigned     HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    logic [N_IN-1:0]            gnt_q;
    logic [N_IN-1:0]            gnt_d;
    logic [N_IN-1:0][N_OUT-1:0] own_nx;

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        logic [N_IN-1:0] cand;
        logic [N_IN-1:0] others;
        state_e          state_q;
        state_e          state_d;
        logic [SW-1:0]   owner_q;
        logic [SW-1:0]   owner_d;
        logic [SW-1:0]   ptr_q;
        logic [SW-1:0]   ptr_d;
        logic [SW-1:0]   win;
        logic [HW-1:0]   hold_q;
        logic [HW-1:0]   hold_d;

        // Inputs currently asking for this output; out-of-range DEST never matches.
        for (genvar i = 0; i < N_IN; i++) begin : g_cand
            assign cand[i]      = REQ[i] && (DEST[i*DW +: DW] == DW'(o));
            assign own_nx[i][o] = (state_d == BUSY) && (owner_d == SW'(i));
        end

        assign others = cand & ~(N_IN'(1) << owner_q);

        // First candidate at or after the round-robin pointer.
        always_comb begin : p_search
            logic        found;
            int unsigned idx;
            found = 1'b0;
            win   = '0;
            idx   = 0;
            for (int unsigned k = 0; k < N_IN; k++) begin
                idx = (32'(ptr_q) + k) % N_IN;
                if (!found && cand[SW'(idx)]) begin
                    win   = SW'(idx);
                    found = 1'b1;
                end
            end
        end

        always_comb begin : p_next
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            hold_d  = hold_q;
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_d = BUSY;
                        owner_d = win;
                        ptr_d   = SW'((32'(win) + 1) % N_IN);
                        hold_d  = '0;
                    end
                end
                BUSY: begin
                    if (!cand[owner_q]) begin
                        state_d = IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        // Saturated: give way only if someone else is waiting.
                        if (|others) begin
                            state_d = IDLE;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            endcase
        end

        always_ff @(posedge CLK or negedge RST_N) begin : p_state
            if (!RST_N) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
                hold_q  <= hold_d;
            end
        end

        // Owner flop doubles as the select; it keeps its value after release.
        assign SEL[o*SW +: SW] = owner_q;
        assign OEN[o]          = (state_q == BUSY);
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_gnt
        assign gnt_d[i] = |own_nx[i];
    end

    always_ff @(posedge CLK or negedge RST_N) begin : p_gnt
        if (!RST_N) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
        end
    end

    assign GNT = gnt_q;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Directed bench for xbar_rr_arbiter: reset, single grant, parallel outputs,
// round-robin order, preemption after MAX_HOLD and DEST change mid-grant.
module tb_xbar_rr_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic [7:0] DEST;
    logic [3:0] GNT;
    logic [7:0] SEL;
    logic [3:0] OEN;

    int errors = 0;
    int checks = 0;

    xbar_rr_arbiter #(
        .N_IN(4), .N_OUT(4), .SW(2), .DW(2), .MAX_HOLD(8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .DEST  (DEST),
        .GNT   (GNT),
        .SEL   (SEL),
        .OEN   (OEN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        REQ   = 4'b0000;
        DEST  = 8'h00;
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        REQ   = 4'b1111;
        DEST  = 8'h00;
        repeat (2) tick();
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", GNT, 4'b0000); end
        checks++; if (OEN !== 4'b0000) begin errors++; $display("FAIL reset_oen: got %b expected %b", OEN, 4'b0000); end
        checks++; if (SEL !== 8'h00) begin errors++; $display("FAIL reset_sel: got %h expected %h", SEL, 8'h00); end
        RST_N = 1'b1;
        tick();
        checks++; if (OEN !== 4'b0001) begin errors++; $display("FAIL first_grant_oen: got %b expected %b", OEN, 4'b0001); end
        checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL first_grant_gnt: got %b expected %b", GNT, 4'b0001); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL async_reset_gnt: got %b expected %b", GNT, 4'b0000); end
        checks++; if (OEN !== 4'b0000) begin errors++; $display("FAIL async_reset_oen: got %b expected %b", OEN, 4'b0000); end
        REQ = 4'b0000;
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        REQ  = 4'b0100;
        DEST = 8'b00_01_00_00;
        tick();
        checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected %b", GNT, 4'b0100); end
        checks++; if (OEN !== 4'b0010) begin errors++; $display("FAIL single_oen: got %b expected %b", OEN, 4'b0010); end
        checks++; if (SEL !== 8'h08) begin errors++; $display("FAIL single_sel: got %h expected %h", SEL, 8'h08); end
        repeat (12) tick();
        checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL uncontested_hold: got %b expected %b", GNT, 4'b0100); end
        REQ = 4'b0000;
        tick();
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL release_gnt: got %b expected %b", GNT, 4'b0000); end
        checks++; if (OEN !== 4'b0000) begin errors++; $display("FAIL release_oen: got %b expected %b", OEN, 4'b0000); end
        checks++; if (SEL !== 8'h08) begin errors++; $display("FAIL release_sel_hold: got %h expected %h", SEL, 8'h08); end
    endtask

    task automatic test_parallel();
        do_reset();
        REQ  = 4'b1111;
        DEST = 8'b11_10_01_00;
        tick();
        checks++; if (GNT !== 4'b1111) begin errors++; $display("FAIL parallel_gnt: got %b expected %b", GNT, 4'b1111); end
        checks++; if (OEN !== 4'b1111) begin errors++; $display("FAIL parallel_oen: got %b expected %b", OEN, 4'b1111); end
        checks++; if (SEL !== 8'hE4) begin errors++; $display("FAIL parallel_sel: got %h expected %h", SEL, 8'hE4); end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int         order [4];
        logic [3:0] exp;
        order = '{0, 1, 3, 0};
        do_reset();
        REQ  = 4'b1011;
        DEST = 8'h00;
        for (int n = 0; n < 4; n++) begin
            exp = 4'b0001 << order[n];
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++; if (GNT !== exp) begin errors++; $display("FAIL rr_gnt[%0d.%0d]: got %b expected %b", n, c, GNT, exp); end
            end
            checks++; if (SEL[1:0] !== 2'(order[n])) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", n, SEL[1:0], order[n]); end
            REQ[order[n]] = 1'b0;
            tick();
            checks++; if (OEN !== 4'b0000) begin errors++; $display("FAIL rr_dead[%0d]: got oen %b expected %b", n, OEN, 4'b0000); end
            REQ[order[n]] = 1'b1;
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_preempt();
        int         owner;
        logic [3:0] exp;
        do_reset();
        REQ  = 4'b0101;
        DEST = 8'b00_11_00_11;
        for (int r = 0; r < 3; r++) begin
            owner = (r % 2 == 0) ? 0 : 2;
            exp   = 4'b0001 << owner;
            for (int c = 0; c < 8; c++) begin
                tick();
                checks++; if (GNT !== exp) begin errors++; $display("FAIL preempt_gnt[%0d.%0d]: got %b expected %b", r, c, GNT, exp); end
            end
            checks++; if (SEL[7:6] !== 2'(owner)) begin errors++; $display("FAIL preempt_sel[%0d]: got %0d expected %0d", r, SEL[7:6], owner); end
            tick();
            checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL preempt_dead[%0d]: got %b expected %b", r, GNT, 4'b0000); end
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        REQ  = 4'b0001;
        DEST = 8'h00;
        tick();
        REQ = 4'b0010;
        tick();
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL handover_dead: got %b expected %b", GNT, 4'b0000); end
        tick();
        checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL handover_gnt: got %b expected %b", GNT, 4'b0010); end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_dest_change();
        do_reset();
        REQ  = 4'b0010;
        DEST = 8'h00;
        tick();
        checks++; if (OEN !== 4'b0001) begin errors++; $display("FAIL dchg_first_oen: got %b expected %b", OEN, 4'b0001); end
        DEST = 8'b00_00_10_00;
        tick();
        checks++; if (OEN !== 4'b0100) begin errors++; $display("FAIL dchg_oen: got %b expected %b", OEN, 4'b0100); end
        checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL dchg_gnt: got %b expected %b", GNT, 4'b0010); end
        checks++; if (SEL !== 8'h11) begin errors++; $display("FAIL dchg_sel: got %h expected %h", SEL, 8'h11); end
        REQ = 4'b0000;
        tick();
    endtask

    initial begin
        RST_N = 1'b0;
        REQ   = 4'b0000;
        DEST  = 8'h00;
        test_reset();
        test_single();
        test_parallel();
        test_round_robin();
        test_preempt();
        test_back_to_back();
        test_dest_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
